// File: rtl/cpu_control_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Fetches instruction and immediate bytes and steers the ALU and register file.
//
// state   | meaning
// --------+-------------------------------------------------
// BOOT    | one idle cycle after reset
// FETCH   | request opcode byte at pc, wait for mem_ready
// DECODE  | classify ir, pick the next phase
// IMM     | request immediate byte at pc (LDI, JMP, JZ)
// EXEC    | ALU writeback to rd, capture alu_zero
// WB      | immediate writeback to rd
// HALT    | stopped until reset
module cpu_control_fsm (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] mem_addr,
  output logic       mem_req,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  input  logic       alu_zero,
  output logic [1:0] rf_ra,
  output logic [1:0] rf_rb,
  output logic       rf_we,
  output logic [1:0] rf_wa,
  output logic       wb_sel,
  output logic [7:0] imm,
  output logic [7:0] pc,
  output logic       zflag,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_IMM, S_EXEC, S_WB, S_HALT
  } state_t;

  state_t     state;
  logic [7:0] ir;
  logic [2:0] opcode;
  logic [1:0] sub_op;

  assign opcode = ir[7:5];
  assign sub_op = ir[4:3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_BOOT;
      ir    <= 8'h00;
      imm   <= 8'h00;
      pc    <= 8'h00;
      zflag <= 1'b0;
    end else begin
      case (state)
        S_BOOT: state <= S_FETCH;
        S_FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            pc    <= pc + 8'd1;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (opcode < 3'd6)       state <= S_EXEC;
          else if (opcode == 3'd6) state <= S_IMM;
          else begin
            case (sub_op)
              2'b00, 2'b01: state <= S_IMM;
              2'b10:        state <= S_FETCH;
              default:      state <= S_HALT;
            endcase
          end
        end
        S_IMM: begin
          if (mem_ready) begin
            imm <= mem_rdata;
            if (opcode == 3'd6) begin
              pc    <= pc + 8'd1;
              state <= S_WB;
            end else begin
              // only JMP (sub 00) and JZ (sub 01) reach here
              if (sub_op == 2'b00 || zflag) pc <= mem_rdata;
              else                          pc <= pc + 8'd1;
              state <= S_FETCH;
            end
          end
        end
        S_EXEC: begin
          zflag <= alu_zero;
          state <= S_FETCH;
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_BOOT;
      endcase
    end
  end

  // Outputs decode straight from the state register so reset clears them at once
  assign mem_req  = (state == S_FETCH) || (state == S_IMM);
  assign mem_addr = pc;
  assign rf_we    = (state == S_EXEC) || (state == S_WB);
  assign wb_sel   = (state == S_WB);
  assign halted   = (state == S_HALT);
  assign alu_op   = ir[7:5];
  assign rf_ra    = ir[4:3];
  assign rf_rb    = ir[2:1];
  assign rf_wa    = ir[4:3];

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Bench for cpu_control_fsm: an instruction-level model expands each instruction
// into its expected per-cycle bus/control trace, which is replayed against the DUT.
module tb_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_addr;
  logic       mem_req;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ready = 1'b0;
  logic [2:0] alu_op;
  logic       alu_zero = 1'b0;
  logic [1:0] rf_ra, rf_rb, rf_wa;
  logic       rf_we, wb_sel, zflag, halted;
  logic [7:0] imm, pc;

  cpu_control_fsm dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .alu_op(alu_op),
    .alu_zero(alu_zero), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_we(rf_we),
    .rf_wa(rf_wa), .wb_sel(wb_sel), .imm(imm), .pc(pc), .zflag(zflag),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         req, rdy, az, we, wbs, halt, z;
    logic [7:0] rd, ir, pc, imm;
  } rec_t;

  rec_t       q[$];
  bit         az_q[$];
  logic [7:0] mem [256];
  logic [7:0] m_pc, m_ir, m_imm;
  bit         m_z, m_halt;
  int         next_wait = -1;
  int         max_w = 0;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'h00; m_imm = 8'h00; m_z = 1'b0; m_halt = 1'b0;
    q.delete(); az_q.delete(); next_wait = -1;
  endtask

  // One expected cycle, showing the architectural state visible during it
  task automatic cyc(bit req, bit rdy, logic [7:0] rd, bit we, bit wbs, bit halt, bit az);
    rec_t r;
    r.req = req; r.rdy = rdy; r.rd = rd; r.we = we; r.wbs = wbs; r.halt = halt;
    r.az = az; r.ir = m_ir; r.pc = m_pc; r.imm = m_imm; r.z = m_z;
    q.push_back(r);
  endtask

  task automatic read_byte(output logic [7:0] b);
    int w;
    w = (next_wait >= 0) ? next_wait : $urandom_range(0, max_w);
    next_wait = -1;
    for (int i = 0; i < w; i++) cyc(1, 0, 8'($urandom), 0, 0, 0, rb());
    b = mem[m_pc];
    cyc(1, 1, b, 0, 0, 0, rb());
  endtask

  task automatic step();
    logic [7:0] b;
    bit az;
    read_byte(b);
    m_ir = b;
    m_pc = m_pc + 8'd1;
    cyc(0, rb(), 8'($urandom), 0, 0, 0, rb());
    if (m_ir[7:5] < 3'd6) begin
      az = (az_q.size() > 0) ? az_q.pop_front() : rb();
      cyc(0, rb(), 8'($urandom), 1, 0, 0, az);
      m_z = az;
    end else if (m_ir[7:5] == 3'd6) begin
      read_byte(b);
      m_imm = b;
      m_pc = m_pc + 8'd1;
      cyc(0, rb(), 8'($urandom), 1, 1, 0, rb());
    end else begin
      case (m_ir[4:3])
        2'd0: begin read_byte(b); m_imm = b; m_pc = b; end
        2'd1: begin read_byte(b); m_imm = b; m_pc = m_z ? b : m_pc + 8'd1; end
        2'd2: ;
        default: m_halt = 1'b1;
      endcase
    end
  endtask

  task automatic gen_tail();
    if (m_halt) for (int i = 0; i < 6; i++) cyc(0, rb(), 8'($urandom), 0, 0, 1, rb());
    else        for (int i = 0; i < 3; i++) cyc(1, 0, 8'($urandom), 0, 0, 0, rb());
  endtask

  task automatic gen_run(int n);
    for (int i = 0; i < n && !m_halt; i++) step();
    gen_tail();
  endtask

  // Replay: drive inputs just after the rising edge, compare on the falling edge
  task automatic run_queue(string tag);
    rec_t r;
    logic [37:0] g, e;
    int n = 0;
    while (q.size() > 0) begin
      r = q.pop_front();
      mem_ready = r.rdy; mem_rdata = r.rd; alu_zero = r.az;
      @(negedge clk);
      g = {mem_req, mem_addr, alu_op, rf_ra, rf_rb, rf_we, rf_wa, wb_sel, imm, pc, zflag, halted};
      e = {r.req, r.pc, r.ir[7:5], r.ir[4:3], r.ir[2:1], r.we, r.ir[4:3], r.wbs,
           r.imm, r.pc, r.z, r.halt};
      chk($sformatf("%s cycle %0d", tag, n), 64'(g), 64'(e));
      n++;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 chk("async_reset", 64'({mem_req, rf_we, wb_sel, halted, pc, imm, zflag, alu_op, rf_ra, rf_rb, rf_wa}), 64'd0);
    @(negedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    mem_ready = 1'b1; mem_rdata = 8'($urandom);
    #1 chk("boot", 64'({mem_req, rf_we, wb_sel, halted, pc, imm, zflag, alu_op}), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    for (int i = 0; i < 256; i++) mem[i] = 8'hF8;

    // Directed: ALU, LDI, JZ taken / not taken, JMP via 0xFE/0xFF, HALT
    mem[8'h00] = 8'h08; mem[8'h01] = 8'hD0; mem[8'h02] = 8'h5A;
    mem[8'h03] = 8'h20; mem[8'h04] = 8'hE8; mem[8'h05] = 8'h40;
    mem[8'h40] = 8'h20; mem[8'h41] = 8'hE8; mem[8'h42] = 8'h10;
    mem[8'h43] = 8'hE0; mem[8'h44] = 8'hFE;
    mem[8'hFE] = 8'hE0; mem[8'hFF] = 8'h60;
    do_reset();
    az_q.push_back(1'b1); az_q.push_back(1'b1); az_q.push_back(1'b0);
    gen_run(20);
    chk("pin_add_exec", 64'({q[2].we, q[2].wbs, q[2].ir, q[2].pc}), 64'({1'b1, 1'b0, 8'h08, 8'h01}));
    chk("pin_ldi_fetch", 64'({q[3].req, q[3].pc}), 64'({1'b1, 8'h01}));
    chk("pin_ldi_wb", 64'({q[6].we, q[6].wbs, q[6].imm, q[6].pc, q[6].z}), 64'({1'b1, 1'b1, 8'h5A, 8'h03, 1'b1}));
    chk("pin_jz_taken", 64'({q[13].req, q[13].pc, q[13].z}), 64'({1'b1, 8'h40, 1'b1}));
    chk("pin_jz_not", 64'({q[19].req, q[19].pc, q[19].z}), 64'({1'b1, 8'h43, 1'b0}));
    chk("pin_imm_ff", 64'({q[24].req, q[24].pc}), 64'({1'b1, 8'hFF}));
    chk("pin_halt", 64'({q[27].halt, q[27].req, q[27].pc}), 64'({1'b1, 1'b0, 8'h61}));
    run_queue("prog1");

    // Directed: JMP to 0xFF, ADD there with 3 wait states, pc wraps to 0x00
    for (int i = 0; i < 256; i++) mem[i] = 8'hF8;
    mem[8'h00] = 8'hE0; mem[8'h01] = 8'hFF; mem[8'hFF] = 8'h08;
    do_reset();
    step();
    next_wait = 3;
    step();
    gen_tail();
    chk("pin_wait", 64'({q[3].req, q[3].rdy, q[3].pc, q[5].req, q[5].rdy, q[5].pc, q[6].rdy, q[6].pc}),
        64'({1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 8'hFF}));
    chk("pin_wrap", 64'({q[7].pc, q[9].req, q[9].pc}), 64'({8'h00, 1'b1, 8'h00}));
    run_queue("prog2");

    // Directed: NOP is two cycles, then HALT
    mem[8'h00] = 8'hF0; mem[8'h01] = 8'hF8;
    do_reset();
    gen_run(5);
    chk("pin_nop", 64'({q[2].req, q[2].pc}), 64'({1'b1, 8'h01}));
    run_queue("prog3");

    // Directed: reset lands while the LDI immediate fetch is stalled
    mem[8'h00] = 8'hD0;
    do_reset();
    read_byte(b);
    m_ir = b;
    m_pc = m_pc + 8'd1;
    cyc(0, rb(), 8'($urandom), 0, 0, 0, rb());
    for (int i = 0; i < 3; i++) cyc(1, 0, 8'($urandom), 0, 0, 0, rb());
    run_queue("imm_stall");

    // Random programs with random wait states
    for (int run = 0; run < 8; run++) begin
      do_reset();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      max_w = 2;
      gen_run(40);
      run_queue($sformatf("rand%0d", run));
    end
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
